ultrasonic_scanner: RTL and testbench
=====================================

// Module: ultrasonic_scanner
// PURPOSE
//  Multiplexed HC-SR04-style ranging engine inside robot_top_module; drives trig_tx/mux_sensor_select pads, consumes echo_rx.
//  Round-robin over NUM_SENSORS through external 16:1 mux: select, settle, 10us trigger, time echo pulse in microseconds.
//  Publishes one result per sensor per scan plus per-sensor obstacle flags for the navigation/motor stage.
// PARAMETERS
//  CLK_DIV_US      50     clk cycles per 1us tick (50 MHz clk); >=2
//  NUM_SENSORS     4      sensors scanned, 1..16; select values 0..NUM_SENSORS-1
//  SETTLE_US       20     mux settle time after select change, before trigger
//  TRIG_US         10     trig_tx high width
//  ECHO_TIMEOUT_US 30000  max wait for echo rise, and max echo width; <=65534
//  GAP_US          60000  dead time after each measurement (ringing decay)
//  NEAR_THRESH_US  1160   obstacle threshold (~20 cm at 58 us/cm)
// PORTS
//  clk                input  1   system clock
//  reset              input  1   synchronous, active-high
//  robot_enable       input  1   1 = scanning allowed
//  echo_rx            input  1   echo from mux, async, active-high
//  trig_tx            output 1   trigger pulse to selected sensor
//  mux_sensor_select  output 4   external mux address
//  meas_valid         output 1   1-cycle strobe: new result on meas_* this cycle
//  meas_sensor        output 4   sensor index of the result
//  meas_echo_us       output 16  echo width in us (truncated); 16'hFFFF on timeout
//  meas_timeout       output 1   result is a timeout (no echo, or echo too long)
//  obstacle_near      output NUM_SENSORS  per-sensor flag, held until that sensor's next result
// BEHAVIOUR
//  Reset: state IDLE, trig_tx=0, mux_sensor_select=0, meas_valid=0, meas_sensor=0, meas_echo_us=0, meas_timeout=0, obstacle_near=0, prescaler=0.
//  echo_rx -> 2-FF synchronizer (echo_s); echo_s lags pad by 2 cycles; edge detect on echo_s vs. its delayed copy.
//  us tick: prescaler counts 0..CLK_DIV_US-1, tick on wrap; cleared on every state entry, so a state lasting N us is exactly N*CLK_DIV_US cycles.
//  FSM:
//   IDLE: robot_enable=1 -> SETTLE for sensor idx (idx=0 after reset or enable loss).
//   SETTLE: mux_sensor_select=idx; after SETTLE_US ticks -> TRIG.
//   TRIG: trig_tx=1 for TRIG_US ticks, then trig_tx=0 -> WAIT_RISE.
//   WAIT_RISE: requires a rising edge of echo_s (echo already high on entry is ignored until it goes low and rises again).
//              edge -> MEASURE with count=0; ECHO_TIMEOUT_US ticks without edge -> RESULT(timeout).
//   MEASURE: count += 1 per tick while echo_s=1; falling edge -> RESULT(count); count reaching ECHO_TIMEOUT_US -> RESULT(timeout).
//   RESULT (1 cycle): meas_valid=1, meas_sensor=idx, meas_echo_us=count or 16'hFFFF, meas_timeout accordingly;
//              obstacle_near[idx] = !timeout && count < NEAR_THRESH_US; other bits unchanged -> GAP.
//   GAP: GAP_US ticks; idx = (idx==NUM_SENSORS-1) ? 0 : idx+1; -> SETTLE if robot_enable else IDLE.
//  meas_sensor/meas_echo_us/meas_timeout hold between strobes; meas_valid high exactly one cycle per measurement.
//  robot_enable=0 in any state: next cycle IDLE, trig_tx=0, idx=0, no meas_valid for the aborted measurement; obstacle_near kept.
//  Synchronous reset mid-operation: all state/outputs to reset values on the next edge, incl. in-flight trigger.
//  Echo of width 0 us (falls before first tick) reports meas_echo_us=0, near=1.
//  NUM_SENSORS=1: select stays 0, scan repeats on sensor 0.
// TESTING (bench params: CLK_DIV_US=4, SETTLE_US=2, TRIG_US=3, ECHO_TIMEOUT_US=100, GAP_US=5, NEAR_THRESH_US=20, NUM_SENSORS=3)
//  Enable, echo high 50us after trigger, width 37us on sensor 0 -> trig_tx high exactly 12 cycles; meas_valid once: sensor=0, echo_us=37 (+/-1), timeout=0, near[0]=0.
//  Echo width 12us on sensor 1 -> echo_us=12, near[1]=1; near[0] unchanged; select sequence 0,1,2,0 across scans.
//  No echo on sensor 2 -> meas_valid after 100us in WAIT_RISE, echo_us=16'hFFFF, timeout=1, near[2]=0.
//  Echo stuck high 150us -> RESULT at count 100, timeout=1, echo_us=16'hFFFF; stuck-high at next WAIT_RISE entry not measured until low->high.
//  Drop robot_enable during MEASURE -> trig_tx=0, no meas_valid, state IDLE next cycle; re-enable starts at sensor 0.
//  Assert reset during TRIG -> trig_tx=0 and all outputs at reset values one edge later; glitch-free restart after release.

Source files
------------

// File: rtl/ultrasonic_scanner_if.sv
// Ranging-engine pad/result bundle: sensor pads plus the per-measurement result bus.
// Latency: none (wires only).
// Backpressure: none; results are strobes and the consumer must take them when meas_valid is high.
// Ports: robot_enable, echo_rx (into scanner); trig_tx, mux_sensor_select,
//        meas_valid/meas_sensor/meas_echo_us/meas_timeout, obstacle_near (out of scanner).
interface ultrasonic_scanner_if #(
  parameter int NUM_SENSORS = 4
);
  logic                   robot_enable;
  logic                   echo_rx;
  logic                   trig_tx;
  logic [3:0]             mux_sensor_select;
  logic                   meas_valid;
  logic [3:0]             meas_sensor;
  logic [15:0]            meas_echo_us;
  logic                   meas_timeout;
  logic [NUM_SENSORS-1:0] obstacle_near;

  // Scanner side.
  modport master (
    input  robot_enable, echo_rx,
    output trig_tx, mux_sensor_select, meas_valid, meas_sensor,
           meas_echo_us, meas_timeout, obstacle_near
  );

  // Consumer / pad-model side.
  modport slave (
    output robot_enable, echo_rx,
    input  trig_tx, mux_sensor_select, meas_valid, meas_sensor,
           meas_echo_us, meas_timeout, obstacle_near
  );
endinterface

// File: rtl/ultrasonic_scanner.sv
// Multiplexed HC-SR04 ranging engine: round-robin select, settle, trigger, time echo in us.
// Latency: one result per sensor per scan; echo_rx reaches the FSM through a 2-FF synchronizer.
// Backpressure: none; meas_valid is a 1-cycle strobe and results hold until the next strobe.
// Ports: clk, reset (sync, active-high); bus (master modport) carries pads and result outputs.
module ultrasonic_scanner #(
  parameter int CLK_DIV_US      = 50,
  parameter int NUM_SENSORS     = 4,
  parameter int SETTLE_US       = 20,
  parameter int TRIG_US         = 10,
  parameter int ECHO_TIMEOUT_US = 30000,
  parameter int GAP_US          = 60000,
  parameter int NEAR_THRESH_US  = 1160
) (
  input  logic                   clk,
  input  logic                   reset,
  ultrasonic_scanner_if.master   bus
);

  localparam int PW = $clog2(CLK_DIV_US);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_TRIG      = 3'd2;
  localparam logic [2:0] ST_WAIT_RISE = 3'd3;
  localparam logic [2:0] ST_MEASURE   = 3'd4;
  localparam logic [2:0] ST_RESULT    = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

  localparam logic [3:0] LAST_IDX = 4'(NUM_SENSORS - 1);

  logic [2:0]             state, state_nxt;
  logic [3:0]             idx, idx_nxt;
  logic [PW-1:0]          presc;
  logic [15:0]            us_cnt;
  logic [15:0]            count;
  logic                   echo_meta, echo_s, echo_d;
  logic                   rise, fall, tick, enter, res_timeout, near_hit;
  logic                   trig_q, valid_q, timeout_q;
  logic [3:0]             mux_q, sensor_q;
  logic [15:0]            echo_us_q;
  logic [NUM_SENSORS-1:0] near_q;

  assign rise  = echo_s & ~echo_d;
  assign fall  = ~echo_s & echo_d;
  assign tick  = (presc == PW'(CLK_DIV_US - 1));
  assign enter = (state_nxt != state);
  assign near_hit = !res_timeout && (count < 16'(NEAR_THRESH_US));

  always_comb begin
    state_nxt   = state;
    res_timeout = 1'b0;
    case (state)
      ST_IDLE:      if (bus.robot_enable) state_nxt = ST_SETTLE;
      ST_SETTLE:    if (tick && us_cnt == 16'(SETTLE_US - 1)) state_nxt = ST_TRIG;
      ST_TRIG:      if (tick && us_cnt == 16'(TRIG_US - 1)) state_nxt = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        // Only a genuine low->high transition starts timing; a level already high is ignored.
        if (rise) begin
          state_nxt = ST_MEASURE;
        end else if (tick && us_cnt == 16'(ECHO_TIMEOUT_US - 1)) begin
          state_nxt   = ST_RESULT;
          res_timeout = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          state_nxt = ST_RESULT;
        end else if (tick && echo_s && count == 16'(ECHO_TIMEOUT_US - 1)) begin
          state_nxt   = ST_RESULT;
          res_timeout = 1'b1;
        end
      end
      ST_RESULT:    state_nxt = ST_GAP;
      ST_GAP: begin
        if (tick && us_cnt == 16'(GAP_US - 1)) begin
          state_nxt = bus.robot_enable ? ST_SETTLE : ST_IDLE;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
    // Enable loss aborts anything in flight, including a pending result.
    if (!bus.robot_enable) state_nxt = ST_IDLE;
  end

  always_comb begin
    idx_nxt = idx;
    if (!bus.robot_enable) begin
      idx_nxt = 4'd0;
    end else if (state == ST_GAP && state_nxt != ST_GAP) begin
      idx_nxt = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 4'd0;
      presc     <= '0;
      us_cnt    <= 16'd0;
      count     <= 16'd0;
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
      trig_q    <= 1'b0;
      mux_q     <= 4'd0;
      valid_q   <= 1'b0;
      sensor_q  <= 4'd0;
      echo_us_q <= 16'd0;
      timeout_q <= 1'b0;
      near_q    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      echo_meta <= bus.echo_rx;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;

      // Prescaler restarts on every state entry so state durations are exact multiples of 1us.
      presc  <= (enter || tick) ? '0 : presc + 1'b1;
      us_cnt <= enter ? 16'd0 : (tick ? us_cnt + 16'd1 : us_cnt);

      if (enter && state_nxt == ST_MEASURE) begin
        count <= 16'd0;
      end else if (state == ST_MEASURE && tick && echo_s) begin
        count <= count + 16'd1;
      end

      // Registered from the next state so trig_tx is high for exactly the TRIG state cycles.
      trig_q <= (state_nxt == ST_TRIG);

      if (enter && state_nxt == ST_SETTLE) mux_q <= idx_nxt;

      valid_q <= 1'b0;
      if (enter && state_nxt == ST_RESULT) begin
        valid_q   <= 1'b1;
        sensor_q  <= idx;
        echo_us_q <= res_timeout ? 16'hFFFF : count;
        timeout_q <= res_timeout;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (idx == 4'(i)) near_q[i] <= near_hit;
        end
      end
    end
  end

  assign bus.trig_tx           = trig_q;
  assign bus.mux_sensor_select = mux_q;
  assign bus.meas_valid        = valid_q;
  assign bus.meas_sensor       = sensor_q;
  assign bus.meas_echo_us      = echo_us_q;
  assign bus.meas_timeout      = timeout_q;
  assign bus.obstacle_near     = near_q;

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Scoreboard bench for ultrasonic_scanner: echo pulses modelled per trigger, results checked from a queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_ultrasonic_scanner;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ultrasonic_scanner_if #(.NUM_SENSORS(NS)) bus();

  ultrasonic_scanner #(
    .CLK_DIV_US(4), .NUM_SENSORS(NS), .SETTLE_US(2), .TRIG_US(3),
    .ECHO_TIMEOUT_US(100), .GAP_US(5), .NEAR_THRESH_US(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // dly < 0 means no echo for that trigger; dly/wid are in clk cycles after trig_tx falls.
  typedef struct { int dly; int wid; } echo_spec_t;
  typedef struct { int sensor; int echo; int tol; int to; int near; } exp_t;

  echo_spec_t spec_q[$];
  exp_t       exp_q[$];
  int         sel_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         check_trig = 1'b1;
  int         trig_run = 0;
  exp_t       mon_e;
  echo_spec_t gen_s;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_range(string name, int got, int lo, int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic drive_echo(int dly, int wid);
    repeat (dly) @(posedge clk);
    #1 bus.echo_rx = 1'b1;
    repeat (wid) @(posedge clk);
    #1 bus.echo_rx = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d results pending expected 0", name, exp_q.size());
    end
  endtask

  // Echo pad model: each trigger falling edge consumes one echo description.
  always @(negedge bus.trig_tx) begin
    if (spec_q.size() > 0) begin
      gen_s = spec_q.pop_front();
      if (gen_s.dly >= 0) begin
        fork
          drive_echo(gen_s.dly, gen_s.wid);
        join_none
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sensor %0d expected no result", bus.meas_sensor);
      end else begin
        mon_e = exp_q.pop_front();
        chk("meas_sensor", int'(bus.meas_sensor), mon_e.sensor);
        chk_range("meas_echo_us", int'(bus.meas_echo_us),
                  mon_e.echo - mon_e.tol, mon_e.echo + mon_e.tol);
        chk("meas_timeout", int'(bus.meas_timeout), mon_e.to);
        chk("obstacle_near", int'(bus.obstacle_near), mon_e.near);
      end
    end
  end

  // Trigger monitor: select at trigger start and trigger width.
  always @(negedge clk) begin
    if (bus.trig_tx === 1'b1) begin
      if (trig_run == 0) begin
        if (sel_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trigger: got select %0d expected no trigger",
                   bus.mux_sensor_select);
        end else begin
          chk("mux_sensor_select", int'(bus.mux_sensor_select), sel_q.pop_front());
        end
      end
      trig_run++;
    end else begin
      if (trig_run != 0 && check_trig) chk("trig_width", trig_run, 12);
      trig_run = 0;
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_trig_tx"},      int'(bus.trig_tx), 0);
    chk({tag, "_mux_select"},   int'(bus.mux_sensor_select), 0);
    chk({tag, "_meas_valid"},   int'(bus.meas_valid), 0);
    chk({tag, "_meas_sensor"},  int'(bus.meas_sensor), 0);
    chk({tag, "_meas_echo_us"}, int'(bus.meas_echo_us), 0);
    chk({tag, "_meas_timeout"}, int'(bus.meas_timeout), 0);
    chk({tag, "_near"},         int'(bus.obstacle_near), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset            = 1'b1;
    bus.robot_enable = 1'b0;
    bus.echo_rx      = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // Scans: 37us echo, 12us echo, no echo, stuck-high 150us, stuck tail ignored, then aborted scan.
    sel_q  = '{0, 1, 2, 0, 1, 2};
    spec_q = '{'{200, 148}, '{200, 48}, '{-1, 0}, '{200, 600}, '{-1, 0}, '{40, 80}};
    exp_q.push_back('{sensor: 0, echo: 37,    tol: 1, to: 0, near: 3'b000});
    exp_q.push_back('{sensor: 1, echo: 12,    tol: 1, to: 0, near: 3'b010});
    exp_q.push_back('{sensor: 2, echo: 65535, tol: 0, to: 1, near: 3'b010});
    exp_q.push_back('{sensor: 0, echo: 65535, tol: 0, to: 1, near: 3'b010});
    exp_q.push_back('{sensor: 1, echo: 65535, tol: 0, to: 1, near: 3'b000});
    bus.robot_enable = 1'b1;
    wait_drain("scans_1_to_5", 20000);

    // Drop enable while the sensor-2 echo is being timed.
    n = 0;
    while (bus.echo_rx !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_echo_seen", int'(bus.echo_rx), 1);
    repeat (20) @(negedge clk);
    bus.robot_enable = 1'b0;
    @(posedge clk);
    #1 chk("abort_trig_tx", int'(bus.trig_tx), 0);
    repeat (300) @(negedge clk);
    chk("abort_select_consumed", sel_q.size(), 0);

    // Re-enable restarts at sensor 0; 2-cycle echo ends before the first us tick.
    sel_q.push_back(0);
    spec_q.push_back('{20, 2});
    exp_q.push_back('{sensor: 0, echo: 0, tol: 0, to: 0, near: 3'b001});
    bus.robot_enable = 1'b1;
    wait_drain("zero_width_scan", 2000);

    // Reset during the sensor-1 trigger.
    sel_q.push_back(1);
    spec_q.push_back('{-1, 0});
    n = 0;
    while (bus.trig_tx !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_trig_seen", int'(bus.trig_tx), 1);
    repeat (5) @(negedge clk);
    check_trig = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    sel_q.push_back(0);
    spec_q.push_back('{80, 32});
    exp_q.push_back('{sensor: 0, echo: 8, tol: 1, to: 0, near: 3'b001});
    reset = 1'b0;
    @(posedge clk);
    #1 check_trig = 1'b1;
    wait_drain("restart_scan", 2000);
    chk("select_queue_drained", sel_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
